// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the two source registers of a decoded
// instruction, bypasses a same-cycle write-back, detects load-use hazards
// against the instruction in EX and holds the result in the ID/EX register.
module operand_fetch #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic [4:0]       ReadAdd1,
    output logic [4:0]       ReadAdd2,
    input  logic [31:0]      Data1,
    input  logic [31:0]      Data2,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    input  logic             ex_load,
    input  logic [4:0]       ex_rd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_rs1_val,
    output logic [31:0]      out_rs2_val,
    output logic [4:0]       out_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  opcode;
    logic [31:0] rs1Val;
    logic [31:0] rs2Val;
    logic        usesRs1;
    logic        usesRs2;
    logic        hazard;
    logic        advance;

    logic             outValid_q,  outValid_d;
    logic [31:0]      outPc_q,     outPc_d;
    logic [31:0]      outInstr_q,  outInstr_d;
    logic [31:0]      outRs1Val_q, outRs1Val_d;
    logic [31:0]      outRs2Val_q, outRs2Val_d;
    logic [4:0]       outRd_q,     outRd_d;
    logic [CNT_W-1:0] stallCnt_q,  stallCnt_d;

    assign rs1      = in_instr[19:15];
    assign rs2      = in_instr[24:20];
    assign opcode   = in_instr[6:0];
    assign ReadAdd1 = rs1;
    assign ReadAdd2 = rs2;

    // Source operand selection: x0 reads as zero, a write-back to the same register wins over the register file
    always_comb begin
        rs1Val = Data1;
        rs2Val = Data2;
        if (rs1 == 5'd0) begin
            rs1Val = 32'd0;
        end else if (wb_en && (wb_addr == rs1)) begin
            rs1Val = wb_data;
        end
        if (rs2 == 5'd0) begin
            rs2Val = 32'd0;
        end else if (wb_en && (wb_addr == rs2)) begin
            rs2Val = wb_data;
        end
    end

    // Operand usage decode and load-use hazard detection against the load in EX
    always_comb begin
        usesRs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
        usesRs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
        hazard  = in_valid && ex_load && (ex_rd != 5'd0) &&
                  ((usesRs1 && (ex_rd == rs1)) || (usesRs2 && (ex_rd == rs2)));
        advance  = !outValid_q || out_ready;
        in_ready = advance && !hazard && !flush;
    end

    // Next state of the ID/EX slot: flush squashes, advance either captures or inserts a bubble, otherwise hold
    always_comb begin
        outValid_d  = outValid_q;
        outPc_d     = outPc_q;
        outInstr_d  = outInstr_q;
        outRs1Val_d = outRs1Val_q;
        outRs2Val_d = outRs2Val_q;
        outRd_d     = outRd_q;
        stallCnt_d  = stallCnt_q;
        if (flush) begin
            outValid_d = 1'b0;
        end else if (advance) begin
            if (in_valid && !hazard) begin
                outValid_d  = 1'b1;
                outPc_d     = in_pc;
                outInstr_d  = in_instr;
                outRs1Val_d = rs1Val;
                outRs2Val_d = rs2Val;
                outRd_d     = in_instr[11:7];
            end else begin
                outValid_d = 1'b0;
            end
        end
        if (hazard && !flush && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    // ID/EX register and stall counter, cleared asynchronously so a held instruction is discarded on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q  <= 1'b0;
            outPc_q     <= 32'd0;
            outInstr_q  <= 32'd0;
            outRs1Val_q <= 32'd0;
            outRs2Val_q <= 32'd0;
            outRd_q     <= 5'd0;
            stallCnt_q  <= '0;
        end else begin
            outValid_q  <= outValid_d;
            outPc_q     <= outPc_d;
            outInstr_q  <= outInstr_d;
            outRs1Val_q <= outRs1Val_d;
            outRs2Val_q <= outRs2Val_d;
            outRd_q     <= outRd_d;
            stallCnt_q  <= stallCnt_d;
        end
    end

    assign out_valid   = outValid_q;
    assign out_pc      = outPc_q;
    assign out_instr   = outInstr_q;
    assign out_rs1_val = outRs1Val_q;
    assign out_rs2_val = outRs2Val_q;
    assign out_rd      = outRd_q;
    assign stall_cnt   = stallCnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: scenario tasks plus a scoreboard that checks
// every instruction leaving the ID/EX register against the expected operands.
module tb_operand_fetch;

    localparam int CNT_W = 3;
    localparam int SAT   = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [4:0]  rd;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic [4:0]       ReadAdd1;
    logic [4:0]       ReadAdd2;
    logic [31:0]      Data1;
    logic [31:0]      Data2;
    logic             wb_en;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_data;
    logic             ex_load;
    logic [4:0]       ex_rd;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [31:0]      out_rs1_val;
    logic [31:0]      out_rs2_val;
    logic [4:0]       out_rd;
    logic [CNT_W-1:0] stall_cnt;

    exp_t sb[$];
    int   checkCount = 0;
    int   errorCount = 0;
    int   expCnt = 0;

    always #5 clk = ~clk;

    operand_fetch #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .ReadAdd1(ReadAdd1), .ReadAdd2(ReadAdd2),
        .Data1(Data1), .Data2(Data2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_load(ex_load), .ex_rd(ex_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .stall_cnt(stall_cnt)
    );

    function automatic logic [31:0] mkR(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        return {7'b0000000, r2, r1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] mkI(input logic [4:0] rd, input logic [4:0] r1, input logic [11:0] imm);
        return {imm, r1, 3'b000, rd, 7'b0010011};
    endfunction

    // Reference operand value: x0 is zero, a matching write-back wins, else the register file
    function automatic logic [31:0] refVal(input logic [4:0] rs, input logic [31:0] data,
                                           input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if (rs == 5'd0) return 32'd0;
        if (we && (wa == rs)) return wd;
        return data;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                                 input logic [31:0] d1, input logic [31:0] d2);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        Data1    = d1;
        Data2    = d2;
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [4:0] rd);
        exp_t e;
        e.pc = pc; e.instr = instr; e.rs1v = v1; e.rs2v = v2; e.rd = rd;
        sb.push_back(e);
    endtask

    // Scoreboard: an instruction handed to execute this cycle must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            checkCount++;
            if (sb.size() == 0) begin
                errorCount++;
                $display("[TB] FAIL sb_unexpected: got pc=%h instr=%h with nothing expected", out_pc, out_instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_pc !== e.pc || out_instr !== e.instr || out_rs1_val !== e.rs1v ||
                    out_rs2_val !== e.rs2v || out_rd !== e.rd) begin
                    errorCount++;
                    $display("[TB] FAIL sb_data: got pc=%h instr=%h rs1=%h rs2=%h rd=%0d expected pc=%h instr=%h rs1=%h rs2=%h rd=%0d",
                             out_pc, out_instr, out_rs1_val, out_rs2_val, out_rd,
                             e.pc, e.instr, e.rs1v, e.rs2v, e.rd);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
        Data1 = 32'd0; Data2 = 32'd0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        ex_load = 1'b0; ex_rd = 5'd0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if (out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_valid: out_valid=%b expected 0", out_valid); end
        checkCount++;
        if (stall_cnt !== '0) begin errorCount++; $display("[TB] FAIL reset_cnt: stall_cnt=%0d expected 0", stall_cnt); end
        checkCount++;
        if ({out_pc, out_instr, out_rs1_val, out_rs2_val, out_rd} !== '0) begin
            errorCount++;
            $display("[TB] FAIL reset_data: pc=%h instr=%h rs1=%h rs2=%h rd=%0d expected all 0",
                     out_pc, out_instr, out_rs1_val, out_rs2_val, out_rd);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        applyStimulus(32'h100, mkR(5'd3, 5'd1, 5'd2), 32'd5, 32'd7);
        #1;
        checkCount++;
        if (ReadAdd1 !== 5'd1 || ReadAdd2 !== 5'd2) begin
            errorCount++;
            $display("[TB] FAIL basic_readadd: ReadAdd1=%0d ReadAdd2=%0d expected 1 2", ReadAdd1, ReadAdd2);
        end
        checkCount++;
        if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL basic_ready: in_ready=%b expected 1", in_ready); end
        pushExp(32'h100, mkR(5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 5'd3);
        tick();
        in_valid = 1'b0;
        checkCount++;
        if (out_valid !== 1'b1) begin errorCount++; $display("[TB] FAIL basic_latency: out_valid=%b expected 1", out_valid); end
        tick();
        checkCount++;
        if (out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL basic_bubble: out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hDEADBEEF;
        applyStimulus(32'h200, mkR(5'd7, 5'd4, 5'd9), 32'h11, 32'h22);
        pushExp(32'h200, mkR(5'd7, 5'd4, 5'd9), 32'hDEADBEEF, 32'h22, 5'd7);
        tick();
        wb_addr = 5'd0;
        applyStimulus(32'h204, mkR(5'd8, 5'd0, 5'd0), 32'h55, 32'h66);
        pushExp(32'h204, mkR(5'd8, 5'd0, 5'd0), 32'd0, 32'd0, 5'd8);
        tick();
        wb_en = 1'b0; wb_addr = 5'd10; wb_data = 32'hCAFEF00D;
        applyStimulus(32'h208, mkR(5'd9, 5'd10, 5'd10), 32'h33, 32'h44);
        pushExp(32'h208, mkR(5'd9, 5'd10, 5'd10), 32'h33, 32'h44, 5'd9);
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_hazard();
        ex_load = 1'b1; ex_rd = 5'd5;
        applyStimulus(32'h300, mkR(5'd11, 5'd1, 5'd5), 32'd1, 32'd2);
        #1;
        checkCount++;
        if (in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL hazard_ready: in_ready=%b expected 0", in_ready); end
        tick();
        expCnt++;
        checkCount++;
        if (out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL hazard_bubble: out_valid=%b expected 0", out_valid); end
        checkCount++;
        if (stall_cnt !== CNT_W'(expCnt)) begin errorCount++; $display("[TB] FAIL hazard_cnt: stall_cnt=%0d expected %0d", stall_cnt, expCnt); end
        ex_load = 1'b0;
        Data2 = 32'h99;
        #1;
        checkCount++;
        if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL hazard_release: in_ready=%b expected 1", in_ready); end
        pushExp(32'h300, mkR(5'd11, 5'd1, 5'd5), 32'd1, 32'h99, 5'd11);
        tick();
        in_valid = 1'b0;
        checkCount++;
        if (out_valid !== 1'b1 || stall_cnt !== CNT_W'(expCnt)) begin
            errorCount++;
            $display("[TB] FAIL hazard_capture: out_valid=%b stall_cnt=%0d expected 1 %0d", out_valid, stall_cnt, expCnt);
        end
        tick();
    endtask

    task automatic test_no_false_stall();
        logic [31:0] lui;
        lui = 32'd0;
        lui[31:25] = 7'h12; lui[24:20] = 5'd5; lui[19:15] = 5'd5; lui[11:7] = 5'd5; lui[6:0] = 7'b0110111;
        ex_load = 1'b1; ex_rd = 5'd5;
        applyStimulus(32'h400, lui, 32'h77, 32'h88);
        #1;
        checkCount++;
        if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL lui_ready: in_ready=%b expected 1", in_ready); end
        pushExp(32'h400, lui, 32'h77, 32'h88, 5'd5);
        tick();
        applyStimulus(32'h404, mkI(5'd6, 5'd3, 12'h005), 32'h13, 32'h14);
        #1;
        checkCount++;
        if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL itype_ready: in_ready=%b expected 1", in_ready); end
        pushExp(32'h404, mkI(5'd6, 5'd3, 12'h005), 32'h13, 32'h14, 5'd6);
        tick();
        ex_rd = 5'd0;
        applyStimulus(32'h408, mkR(5'd1, 5'd0, 5'd0), 32'h15, 32'h16);
        pushExp(32'h408, mkR(5'd1, 5'd0, 5'd0), 32'd0, 32'd0, 5'd1);
        tick();
        in_valid = 1'b0; ex_load = 1'b0;
        checkCount++;
        if (stall_cnt !== CNT_W'(expCnt)) begin errorCount++; $display("[TB] FAIL nostall_cnt: stall_cnt=%0d expected %0d", stall_cnt, expCnt); end
        tick();
    endtask

    task automatic test_hold_flush();
        out_ready = 1'b0;
        applyStimulus(32'h500, mkR(5'd12, 5'd13, 5'd14), 32'hA, 32'hB);
        pushExp(32'h500, mkR(5'd12, 5'd13, 5'd14), 32'hA, 32'hB, 5'd12);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h600 + 32'(i * 4), mkR(5'(i + 20), 5'(i + 1), 5'(i + 2)), 32'(i + 100), 32'(i + 200));
            #1;
            checkCount++;
            if (in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL hold_ready%0d: in_ready=%b expected 0", i, in_ready); end
            tick();
            checkCount++;
            if (out_valid !== 1'b1 || out_pc !== 32'h500 || out_instr !== mkR(5'd12, 5'd13, 5'd14) ||
                out_rs1_val !== 32'hA || out_rs2_val !== 32'hB || out_rd !== 5'd12) begin
                errorCount++;
                $display("[TB] FAIL hold_stable%0d: valid=%b pc=%h rs1=%h rs2=%h rd=%0d expected 1 500 a b 12",
                         i, out_valid, out_pc, out_rs1_val, out_rs2_val, out_rd);
            end
        end
        flush = 1'b1;
        #1;
        checkCount++;
        if (in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL flush_ready: in_ready=%b expected 0", in_ready); end
        tick();
        void'(sb.pop_front());
        checkCount++;
        if (out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL flush_clear: out_valid=%b expected 0", out_valid); end
        out_ready = 1'b1; ex_load = 1'b1; ex_rd = 5'd5;
        applyStimulus(32'h700, mkR(5'd2, 5'd5, 5'd0), 32'd1, 32'd2);
        tick();
        checkCount++;
        if (out_valid !== 1'b0 || stall_cnt !== CNT_W'(expCnt)) begin
            errorCount++;
            $display("[TB] FAIL flush_hazard: out_valid=%b stall_cnt=%0d expected 0 %0d", out_valid, stall_cnt, expCnt);
        end
        flush = 1'b0; ex_load = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        ex_load = 1'b1; ex_rd = 5'd5;
        applyStimulus(32'h800, mkR(5'd1, 5'd5, 5'd0), 32'h21, 32'h22);
        for (int i = 0; i < 10; i++) begin
            tick();
            expCnt = (expCnt == SAT) ? SAT : expCnt + 1;
            checkCount++;
            if (stall_cnt !== CNT_W'(expCnt)) begin
                errorCount++;
                $display("[TB] FAIL sat_cnt%0d: stall_cnt=%0d expected %0d", i, stall_cnt, expCnt);
            end
        end
        ex_load = 1'b0;
        pushExp(32'h800, mkR(5'd1, 5'd5, 5'd0), 32'h21, 32'd0, 5'd1);
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  r1, r2, rd;
        logic [31:0] d1, d2, pc;
        for (int i = 0; i < 8; i++) begin
            r1 = 5'($urandom_range(0, 31)); r2 = 5'($urandom_range(0, 31)); rd = 5'($urandom_range(0, 31));
            d1 = $urandom; d2 = $urandom; pc = 32'h900 + 32'(i * 4);
            wb_en = 1'($urandom_range(0, 1));
            wb_addr = (i % 3 == 0) ? r1 : ((i % 3 == 1) ? r2 : 5'($urandom_range(0, 31)));
            wb_data = $urandom;
            applyStimulus(pc, mkR(rd, r1, r2), d1, d2);
            pushExp(pc, mkR(rd, r1, r2), refVal(r1, d1, wb_en, wb_addr, wb_data),
                    refVal(r2, d2, wb_en, wb_addr, wb_data), rd);
            tick();
            checkCount++;
            if (out_valid !== 1'b1) begin errorCount++; $display("[TB] FAIL b2b_valid%0d: out_valid=%b expected 1", i, out_valid); end
        end
        in_valid = 1'b0; wb_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        applyStimulus(32'hA00, mkR(5'd4, 5'd6, 5'd7), 32'h61, 32'h71);
        pushExp(32'hA00, mkR(5'd4, 5'd6, 5'd7), 32'h61, 32'h71, 5'd4);
        tick();
        ex_load = 1'b1; ex_rd = 5'd6;
        applyStimulus(32'hA04, mkR(5'd8, 5'd6, 5'd1), 32'h1, 32'h2);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if (out_valid !== 1'b0 || stall_cnt !== '0) begin
            errorCount++;
            $display("[TB] FAIL rstmid_async: out_valid=%b stall_cnt=%0d expected 0 0", out_valid, stall_cnt);
        end
        checkCount++;
        if ({out_pc, out_instr, out_rs1_val, out_rs2_val, out_rd} !== '0) begin
            errorCount++;
            $display("[TB] FAIL rstmid_data: pc=%h instr=%h rd=%0d expected 0", out_pc, out_instr, out_rd);
        end
        sb.delete();
        expCnt = 0;
        ex_load = 1'b0; out_ready = 1'b1;
        applyStimulus(32'hB00, mkR(5'd9, 5'd2, 5'd3), 32'hB1, 32'hB2);
        pushExp(32'hB00, mkR(5'd9, 5'd2, 5'd3), 32'hB1, 32'hB2, 5'd9);
        #2;
        rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        checkCount++;
        if (out_valid !== 1'b1 || stall_cnt !== '0) begin
            errorCount++;
            $display("[TB] FAIL rstmid_resume: out_valid=%b stall_cnt=%0d expected 1 0", out_valid, stall_cnt);
        end
        tick();
    endtask

    // Watchdog so a wedged run still ends with a report
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence followed by the scoreboard drain check and summary
    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_hazard();
        test_no_false_stall();
        test_hold_flush();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        checkCount++;
        if (sb.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL sb_drain: %0d expected instructions never seen, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
